// File: rtl/stream_arb_mux.sv
// Round-robin N:1 stream arbiter/multiplexer with a single-beat registered output slot.
// Optional packet-locked arbitration is enabled by defining STREAM_ARB_MUX_PKT_LOCK_EN.
// Without it, every accepted beat re-arbitrates and in_last is sideband only.
module stream_arb_mux #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned PORTS = 2,
  parameter int unsigned SEL_W = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH*PORTS-1:0] in_data_i,
  input  logic [PORTS-1:0]       in_valid_i,
  input  logic [PORTS-1:0]       in_last_i,
  output logic [PORTS-1:0]       in_ready_o,
  output logic [WIDTH-1:0]       out_data_o,
  output logic                   out_valid_o,
  output logic                   out_last_o,
  output logic [SEL_W-1:0]       out_sel_o,
  input  logic                   out_ready_i
);

  logic [SEL_W-1:0] ptr_q;
  logic [WIDTH-1:0] out_data_q;
  logic             out_valid_q;
  logic             out_last_q;
  logic [SEL_W-1:0] out_sel_q;

  logic             load_en;
  logic [SEL_W-1:0] grant;
  logic             grant_vld;
  logic             accept;
  logic [SEL_W-1:0] ptr_inc;
  logic [WIDTH-1:0] sel_data;
  logic             sel_last;

`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
  typedef enum logic [0:0] {StIdle, StLocked} state_e;
  state_e           state_q;
  logic [SEL_W-1:0] lock_q;
`endif

  assign load_en = !out_valid_q || out_ready_i;

  // Grant selection: first valid port at or after ptr, wrapping; a locked packet overrides.
  always_comb begin
    int unsigned idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < PORTS; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= PORTS) idx = idx - PORTS;
      if (!grant_vld && in_valid_i[idx]) begin
        grant     = idx[SEL_W-1:0];
        grant_vld = 1'b1;
      end
    end
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    // Locked port keeps the grant even while it has no valid beat, stalling others.
    if (state_q == StLocked) begin
      grant     = lock_q;
      grant_vld = in_valid_i[lock_q];
    end
`endif
  end

  assign accept   = load_en && grant_vld;
  assign ptr_inc  = (int'(grant) == int'(PORTS) - 1) ? '0 : grant + 1'b1;
  assign sel_data = in_data_i[int'(grant)*WIDTH +: WIDTH];
  assign sel_last = in_last_i[grant];

  // One-hot ready to the granted port only; forced low while reset is held.
  always_comb begin
    in_ready_o = '0;
    for (int unsigned i = 0; i < PORTS; i++) begin
      in_ready_o[i] = !rst && accept && (grant == SEL_W'(i));
    end
  end

  // Output slot, round-robin pointer and (optionally) the packet-lock FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_sel_q   <= '0;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
      state_q     <= StIdle;
      lock_q      <= '0;
`endif
    end else begin
      if (accept) begin
        out_data_q  <= sel_data;
        out_last_q  <= sel_last;
        out_sel_q   <= grant;
        out_valid_q <= 1'b1;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
        unique case (state_q)
          StIdle: begin
            if (sel_last) begin
              ptr_q <= ptr_inc;
            end else begin
              state_q <= StLocked;
              lock_q  <= grant;
            end
          end
          StLocked: begin
            if (sel_last) begin
              state_q <= StIdle;
              ptr_q   <= ptr_inc;
            end
          end
          default: state_q <= StIdle;
        endcase
`else
        ptr_q <= ptr_inc;
`endif
      end else if (out_ready_i) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign out_data_o  = out_data_q;
  assign out_valid_o = out_valid_q;
  assign out_last_o  = out_last_q;
  assign out_sel_o   = out_sel_q;

endmodule

// File: tb/tb_stream_arb_mux.sv
// Self-checking bench for stream_arb_mux (PORTS=4, WIDTH=8, SEL_W=2), both lock modes.
module tb_stream_arb_mux;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] in_data = '0;
  logic [3:0]  in_valid = '0;
  logic [3:0]  in_last = '0;
  logic [3:0]  in_ready;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_last;
  logic [1:0]  out_sel;
  logic        out_ready = 1'b0;

  int tests = 0;
  int fails = 0;

  stream_arb_mux #(.WIDTH(8), .PORTS(4), .SEL_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_data_i  (in_data),
    .in_valid_i (in_valid),
    .in_last_i  (in_last),
    .in_ready_o (in_ready),
    .out_data_o (out_data),
    .out_valid_o(out_valid),
    .out_last_o (out_last),
    .out_sel_o  (out_sel),
    .out_ready_i(out_ready)
  );

  always #5 clk = ~clk;

  // Inputs change 1 time unit after the rising edge; checks happen there or at the falling edge.
  task automatic do_reset();
    rst = 1'b1; in_valid = '0; in_last = '0; in_data = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL rst_valid got %0b exp 0", out_valid); end
    tests++; if (out_data !== 8'h00) begin fails++; $display("FAIL rst_data got %h exp 00", out_data); end
    tests++; if (out_last !== 1'b0) begin fails++; $display("FAIL rst_last got %0b exp 0", out_last); end
    tests++; if (out_sel !== 2'd0) begin fails++; $display("FAIL rst_sel got %0d exp 0", out_sel); end
    in_valid = 4'b1111;
    #1;
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL rst_ready got %b exp 0000", in_ready); end
    // Fill the slot, then assert reset mid-cycle.
    rst = 1'b0; in_valid = 4'b0001; in_last = 4'b1111; in_data = 32'h44332211;
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL pre_rst_valid got %0b exp 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL async_rst_valid got %0b exp 0", out_valid); end
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL async_rst_ready got %b exp 0000", in_ready); end
    in_valid = 4'b0100;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL post_rst_ready got %b exp 0100", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd2 || out_valid !== 1'b1 || out_data !== 8'h33)
      begin fails++; $display("FAIL post_rst_grant got sel=%0d v=%0b d=%h exp sel=2 v=1 d=33", out_sel, out_valid, out_data); end
  endtask

  task automatic test_round_robin();
    do_reset();
    in_valid = 4'b1111; in_last = 4'b1111; in_data = 32'hA3A2A1A0; out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'(k % 4) || out_data !== 8'(8'hA0 + k % 4))
        begin fails++; $display("FAIL rr_beat%0d got v=%0b sel=%0d d=%h exp v=1 sel=%0d d=%h",
                                k, out_valid, out_sel, out_data, k % 4, 8'(8'hA0 + k % 4)); end
    end
    in_valid = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    in_valid = 4'b0010; in_last = 4'b1111; in_data = 32'h00005500; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 4'b0100; in_data = 32'h00660000;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests++;
      if (in_ready !== 4'b0000 || out_valid !== 1'b1 || out_data !== 8'h55 || out_sel !== 2'd1)
        begin fails++; $display("FAIL bp_hold%0d got rdy=%b v=%0b d=%h sel=%0d exp rdy=0000 v=1 d=55 sel=1",
                                k, in_ready, out_valid, out_data, out_sel); end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    #1;
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL bp_release_ready got %b exp 0100", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b1 || out_data !== 8'h66 || out_sel !== 2'd2)
      begin fails++; $display("FAIL bp_next got v=%0b d=%h sel=%0d exp v=1 d=66 sel=2", out_valid, out_data, out_sel); end
    in_valid = '0;
  endtask

  task automatic test_wrap();
    do_reset();
    out_ready = 1'b1; in_last = 4'b1111; in_data = 32'h40302010;
    in_valid = 4'b0100;            // grant 2 -> ptr 3
    @(posedge clk); #1;
    in_valid = 4'b0010;            // from ptr 3 wraps to 1
    @(negedge clk);
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL wrap_ready got %b exp 0010", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_sel !== 2'd1 || out_data !== 8'h20) begin fails++; $display("FAIL wrap_sel got sel=%0d d=%h exp sel=1 d=20", out_sel, out_data); end
    in_valid = 4'b0000;
    @(negedge clk);
    tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL idle_ready got %b exp 0000", in_ready); end
    @(posedge clk); #1;
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL idle_drain got %0b exp 0", out_valid); end
    in_valid = 4'b1111;            // ptr must have held at 2
    @(negedge clk);
    tests++; if (in_ready !== 4'b0100) begin fails++; $display("FAIL ptr_hold got %b exp 0100", in_ready); end
    in_valid = '0;
  endtask

  task automatic test_packet();
    int n_p0;
    int n_p1;
    int exp_sel[5];
    int n_chk;
    logic [3:0] rdy;
    do_reset();
    n_p0 = 0; n_p1 = 0; out_ready = 1'b1;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    exp_sel[0] = 0; exp_sel[1] = 0; exp_sel[2] = 0; exp_sel[3] = 1; exp_sel[4] = 0; n_chk = 4;
`else
    exp_sel[0] = 0; exp_sel[1] = 1; exp_sel[2] = 0; exp_sel[3] = 1; exp_sel[4] = 0; n_chk = 5;
`endif
    for (int c = 0; c < n_chk; c++) begin
      in_valid = {2'b00, 1'b1, (n_p0 < 3)};
      in_last  = {2'b00, 1'b1, (n_p0 == 2)};
      in_data  = {16'h0000, 8'(8'h20 + n_p1), 8'(8'h10 + n_p0)};
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk); #1;
      tests++;
      if (out_valid !== 1'b1 || out_sel !== 2'(exp_sel[c]))
        begin fails++; $display("FAIL pkt_beat%0d got v=%0b sel=%0d exp v=1 sel=%0d", c, out_valid, out_sel, exp_sel[c]); end
      if (rdy[0]) n_p0++;
      if (rdy[1]) n_p1++;
    end
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    // Mid-packet valid gap on port 0 must stall port 1.
    do_reset();
    out_ready = 1'b1; in_data = 32'h00002010;
    in_valid = 4'b0011; in_last = 4'b0010;
    @(posedge clk); #1;
    in_valid = 4'b0010;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      tests++; if (in_ready !== 4'b0000) begin fails++; $display("FAIL gap_ready%0d got %b exp 0000", k, in_ready); end
      @(posedge clk); #1;
    end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL gap_drain got %0b exp 0", out_valid); end
    in_valid = 4'b0011; in_last = 4'b0011; in_data = 32'h00002011;
    @(negedge clk);
    tests++; if (in_ready !== 4'b0001) begin fails++; $display("FAIL gap_resume got %b exp 0001", in_ready); end
    @(posedge clk); #1;
    @(negedge clk);
    tests++; if (in_ready !== 4'b0010) begin fails++; $display("FAIL gap_unlock got %b exp 0010", in_ready); end
`endif
    in_valid = '0;
  endtask

  // Reference model: slot contents plus pointer and lock bookkeeping, derived from the rules.
  task automatic test_random();
    int         m_ptr, m_lidx, g;
    bit         m_lock, m_ov, m_ol, gv, acc, lock_en;
    logic [7:0] m_od;
    int         m_os;
    logic [3:0] exp_rdy;
`ifdef STREAM_ARB_MUX_PKT_LOCK_EN
    lock_en = 1'b1;
`else
    lock_en = 1'b0;
`endif
    do_reset();
    m_ptr = 0; m_lock = 0; m_lidx = 0; m_ov = 0; m_ol = 0; m_od = '0; m_os = 0;
    for (int n = 0; n < 400; n++) begin
      in_valid  = 4'($urandom_range(0, 15)) & 4'($urandom_range(0, 15) | 4'($urandom_range(0, 15)));
      in_last   = 4'($urandom);
      in_data   = $urandom;
      out_ready = ($urandom_range(0, 3) != 0);
      g = 0; gv = 0;
      if (m_lock) begin
        g = m_lidx; gv = in_valid[m_lidx];
      end else begin
        for (int k = 3; k >= 0; k--) begin
          if (in_valid[(m_ptr + k) % 4]) begin g = (m_ptr + k) % 4; gv = 1; end
        end
      end
      acc = gv && (!m_ov || out_ready);
      exp_rdy = acc ? 4'(1 << g) : 4'b0000;
      @(negedge clk);
      tests++; if (in_ready !== exp_rdy) begin fails++; $display("FAIL rnd_ready%0d got %b exp %b", n, in_ready, exp_rdy); end
      if (acc) begin
        m_ov = 1; m_od = in_data[g*8 +: 8]; m_ol = in_last[g]; m_os = g;
        if (!lock_en) m_ptr = (g + 1) % 4;
        else if (!m_lock && !in_last[g]) begin m_lock = 1; m_lidx = g; end
        else if (in_last[g]) begin m_lock = 0; m_ptr = (g + 1) % 4; end
      end else if (out_ready) begin
        m_ov = 0;
      end
      @(posedge clk); #1;
      tests++;
      if (out_valid !== m_ov || (m_ov && (out_data !== m_od || out_last !== m_ol || out_sel !== 2'(m_os))))
        begin fails++; $display("FAIL rnd_out%0d got v=%0b d=%h l=%0b sel=%0d exp v=%0b d=%h l=%0b sel=%0d",
                                n, out_valid, out_data, out_last, out_sel, m_ov, m_od, m_ol, m_os); end
    end
    in_valid = '0;
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_backpressure();
    test_wrap();
    test_packet();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Hard bound in case a task stalls on the clock.
  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1, "timeout");
  end

endmodule
